// File: rtl/muxcont_n.sv
// Output-port arbiter and crossbar-select controller for one NoC router output.
// Optional build macro MUXCONT_STARVE_EN adds per-input unicast starvation counters.
module muxcont_n #(
    parameter int NPORT      = 5,
    parameter int PORTW      = 3,
    parameter int PORTID     = 0,
    parameter int STARVE_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*PORTW-1:0] dst,
    input  logic [NPORT-1:0]       mcast,
    input  logic [NPORT-1:0]       tail,
    input  logic                   out_rdy,
    output logic [NPORT-1:0]       grt,
    output logic [NPORT-1:0]       sel,
    output logic                   busy
);

    // state | meaning
    // IDLE  | no packet owns the output; arbitrate every cycle
    // LOCK  | output owned by 'owner' until its tail flit transfers
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int PTRW = (NPORT > 1) ? $clog2(NPORT) : 1;

    state_t           state, state_nxt;
    logic [NPORT-1:0] owner, owner_nxt;
    logic [PTRW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [NPORT-1:0] v, m_req, u_req, starve_g;
    logic             tail_xfer;

    function automatic logic [NPORT-1:0] rr_pick(input logic [NPORT-1:0] vec,
                                                  input logic [PTRW-1:0]  ptr);
        logic [NPORT-1:0] g;
        logic [PTRW-1:0]  idx;
        logic             found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            idx = PTRW'((int'(ptr) + k) % NPORT);
            if (!found && vec[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PTRW-1:0] next_ptr(input logic [NPORT-1:0] oh);
        logic [PTRW-1:0] w;
        w = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (oh[i]) w = PTRW'(i);
        end
        if (int'(w) == NPORT - 1) return '0;
        return w + PTRW'(1);
    endfunction

    always_comb begin
        v = '0;
        for (int i = 0; i < NPORT; i++) begin
            v[i] = req[i] && (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

    assign m_req = v & mcast;
    assign u_req = v & ~mcast;

`ifdef MUXCONT_STARVE_EN
    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CW-1:0]    wait_cnt [NPORT];
    logic [NPORT-1:0] starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NPORT; i++) begin
            starved[i] = u_req[i] && (wait_cnt[i] == CW'(STARVE_MAX));
        end
    end

    // isolate the lowest starved input
    assign starve_g = starved & (~starved + NPORT'(1));

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (rst_ || !u_req[i] || grt[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CW'(STARVE_MAX)) begin
                wait_cnt[i] <= wait_cnt[i] + CW'(1);
            end
        end
    end
`else
    assign starve_g = '0;
`endif

    always_comb begin
        grt        = '0;
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;

        case (state)
            IDLE: begin
                if (out_rdy) begin
                    if (|starve_g)   grt = starve_g;
                    else if (|m_req) grt = rr_pick(m_req, rr_ptr);
                    else             grt = rr_pick(u_req, rr_ptr);
                end
            end
            LOCK:    grt = owner & v & {NPORT{out_rdy}};
            default: grt = '0;
        endcase

        if (rst_) grt = '0;

        tail_xfer = |(grt & tail);
        // a tail transfer always frees the output, so the next grant is a cycle later
        if (|grt) begin
            if (tail_xfer) begin
                state_nxt  = IDLE;
                owner_nxt  = '0;
                rr_ptr_nxt = next_ptr(grt);
            end else begin
                state_nxt  = LOCK;
                owner_nxt  = grt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            sel    <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (|grt) sel <= grt;
        end
    end

    assign busy = (state == LOCK);

endmodule

// File: tb/tb_muxcont_n.sv
// Scoreboard bench for muxcont_n (NPORT=5, PORTID=0, STARVE_MAX=3); expected
// grant/sel/busy per cycle are queued at drive time and popped when sampled.
module tb_muxcont_n;

    localparam int NPORT      = 5;
    localparam int PORTW      = 3;
    localparam int PORTID     = 0;
    localparam int STARVE_MAX = 3;

    logic                   clk = 1'b0;
    logic                   rst_;
    logic [NPORT-1:0]       req;
    logic [NPORT*PORTW-1:0] dst;
    logic [NPORT-1:0]       mcast;
    logic [NPORT-1:0]       tail;
    logic                   out_rdy;
    logic [NPORT-1:0]       grt;
    logic [NPORT-1:0]       sel;
    logic                   busy;

    typedef struct {
        string            tag;
        logic [NPORT-1:0] grt;
        logic [NPORT-1:0] sel;
        logic             busy;
    } exp_t;

    exp_t             sb[$];
    logic [NPORT-1:0] sel_model;
    int               n_checks = 0;
    int               n_pass   = 0;

    muxcont_n #(
        .NPORT(NPORT), .PORTW(PORTW), .PORTID(PORTID), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_(rst_), .req(req), .dst(dst), .mcast(mcast),
        .tail(tail), .out_rdy(out_rdy), .grt(grt), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // drive one cycle (called at posedge+1), sample at the following negedge
    task automatic cyc(input string tag, input logic [NPORT-1:0] r, input logic [NPORT-1:0] here,
                       input logic [NPORT-1:0] m, input logic [NPORT-1:0] t, input logic rdy,
                       input logic [NPORT-1:0] eg, input logic eb);
        exp_t e;
        req     = r;
        mcast   = m;
        tail    = t;
        out_rdy = rdy;
        for (int i = 0; i < NPORT; i++)
            dst[i*PORTW +: PORTW] = here[i] ? PORTW'(PORTID) : PORTW'(2);
        e.tag  = tag;
        e.grt  = eg;
        e.sel  = sel_model;
        e.busy = eb;
        sb.push_back(e);
        if (eg != '0) sel_model = eg;
        #4;
        e = sb.pop_front();
        check_eq({e.tag, ".grt"}, 32'(grt), 32'(e.grt));
        check_eq({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
        check_eq({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
        @(posedge clk);
        #1;
    endtask

    localparam logic [NPORT-1:0] ALL = '1;
    localparam logic [NPORT-1:0] NO  = '0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NPORT-1:0] starve_exp;
        sel_model = '0;
        rst_      = 1'b1;
        req       = ALL;
        mcast     = NO;
        tail      = NO;
        out_rdy   = 1'b1;
        dst       = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #4;
        check_eq("reset.grt", 32'(grt), 32'(0));
        check_eq("reset.sel", 32'(sel), 32'(0));
        check_eq("reset.busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        rst_ = 1'b0;

        // first cycle after reset: all unicast, single-flit
        cyc("first",  ALL, ALL, NO, ALL, 1'b1, 5'b00001, 1'b0);
        cyc("idle0",  NO,  ALL, NO, NO,  1'b1, 5'b00000, 1'b0);

        // inputs 1 and 3 each send a 3-flit unicast packet (rr_ptr = 1)
        cyc("p1f0",   5'b01010, ALL, NO, NO,       1'b1, 5'b00010, 1'b0);
        cyc("p1f1",   5'b01010, ALL, NO, NO,       1'b1, 5'b00010, 1'b1);
        cyc("p1f2",   5'b01010, ALL, NO, 5'b00010, 1'b1, 5'b00010, 1'b1);
        cyc("p3f0",   5'b01000, ALL, NO, NO,       1'b1, 5'b01000, 1'b0);
        cyc("p3f1",   5'b01000, ALL, NO, NO,       1'b1, 5'b01000, 1'b1);
        cyc("p3f2",   5'b01000, ALL, NO, 5'b01000, 1'b1, 5'b01000, 1'b1);
        cyc("idle1",  NO,       ALL, NO, NO,       1'b1, 5'b00000, 1'b0);

        // multicast 2 beats unicast 0 even though 0 is nearer rr_ptr = 4
        cyc("mc2",    5'b00101, ALL, 5'b00100, 5'b00101, 1'b1, 5'b00100, 1'b0);
        cyc("uc0",    5'b00001, ALL, NO,       5'b00001, 1'b1, 5'b00001, 1'b0);
        cyc("idle2",  NO,       ALL, NO,       NO,       1'b1, 5'b00000, 1'b0);

        // owner 2 drops req for two cycles while input 4 waits (rr_ptr = 1)
        cyc("gapf0",  5'b10100, ALL, NO, NO,       1'b1, 5'b00100, 1'b0);
        cyc("gapf1",  5'b10100, ALL, NO, NO,       1'b1, 5'b00100, 1'b1);
        cyc("gap_a",  5'b10000, ALL, NO, NO,       1'b1, 5'b00000, 1'b1);
        cyc("gap_b",  5'b10000, ALL, NO, NO,       1'b1, 5'b00000, 1'b1);
        cyc("gapf2",  5'b10100, ALL, NO, 5'b00100, 1'b1, 5'b00100, 1'b1);
        cyc("in4",    5'b10000, ALL, NO, 5'b10000, 1'b1, 5'b10000, 1'b0);
        cyc("idle3",  NO,       ALL, NO, NO,       1'b1, 5'b00000, 1'b0);

        // out_rdy low in IDLE and on the tail flit; pointer wrapped to 0
        cyc("nrdy_i", 5'b00010, ALL, NO, NO,       1'b0, 5'b00000, 1'b0);
        cyc("rdyf0",  5'b00010, ALL, NO, NO,       1'b1, 5'b00010, 1'b0);
        cyc("nrdy_a", 5'b00010, ALL, NO, 5'b00010, 1'b0, 5'b00000, 1'b1);
        cyc("nrdy_b", 5'b00010, ALL, NO, 5'b00010, 1'b0, 5'b00000, 1'b1);
        cyc("rdy_t",  5'b00010, ALL, NO, 5'b00010, 1'b1, 5'b00010, 1'b1);
        cyc("single", 5'b00010, ALL, NO, 5'b00010, 1'b1, 5'b00010, 1'b0);
        cyc("idle4",  NO,       ALL, NO, NO,       1'b1, 5'b00000, 1'b0);

        // only input 0 routes here (rr_ptr = 2); others are filtered by dst
        cyc("dstflt", ALL, 5'b00001, NO, ALL, 1'b1, 5'b00001, 1'b0);
        cyc("idle5",  NO,  ALL,      NO, NO,  1'b1, 5'b00000, 1'b0);

        // continuous single-flit multicast from 1 against unicast from 0
        for (int k = 0; k < 6; k++) begin
`ifdef MUXCONT_STARVE_EN
            starve_exp = (k == 3) ? 5'b00001 : 5'b00010;
`else
            starve_exp = 5'b00010;
`endif
            cyc($sformatf("starve%0d", k), 5'b00011, ALL, 5'b00010, 5'b00011, 1'b1,
                starve_exp, 1'b0);
        end
        cyc("idle6",  NO, ALL, NO, NO, 1'b1, 5'b00000, 1'b0);

        // reset mid-packet from input 3, then re-arbitrate from port 0
        cyc("rstf0",  5'b01000, ALL, NO, NO, 1'b1, 5'b01000, 1'b0);
        cyc("rstf1",  5'b01000, ALL, NO, NO, 1'b1, 5'b01000, 1'b1);
        rst_ = 1'b1;
        #4;
        check_eq("midrst.grt", 32'(grt), 32'(0));
        @(posedge clk); #1;
        rst_      = 1'b0;
        sel_model = '0;
        cyc("post0",  5'b01001, ALL, NO, 5'b01001, 1'b1, 5'b00001, 1'b0);
        cyc("post3",  5'b01000, ALL, NO, 5'b01000, 1'b1, 5'b01000, 1'b0);
        cyc("idle7",  NO,       ALL, NO, NO,       1'b1, 5'b00000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
